cpu: RTL and testbench

Single-cycle, word-addressed mini-MIPS processor with on-chip instruction memory, data memory and 32×32 register file. While held in reset, an external loader fills both memories through a shared address/data port. After reset release, the core executes one instruction per clock from address 0. It is the top of the processor design.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/reg_file.sv | 34 +++
 rtl/cpu.sv | 177 +++++++++++++++++
 tb/tb_cpu.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the mini-MIPS core: opcodes, functs, ALU ops, memory geometry.
// Optional feature macro: CPU_SHIFT_EN (enables sll/srl R-type functs).
package cpu_pkg;

  localparam int MEM_DEPTH = 1024;
  localparam int ADDR_W    = 10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b010000;
  localparam logic [5:0] OP_BNE   = 6'b010001;

  localparam logic [5:0] FN_ADD = 6'b000000;
  localparam logic [5:0] FN_SUB = 6'b000001;
  localparam logic [5:0] FN_AND = 6'b000010;
  localparam logic [5:0] FN_OR  = 6'b000011;
  localparam logic [5:0] FN_SLT = 6'b000100;
  localparam logic [5:0] FN_SLL = 6'b000101;
  localparam logic [5:0] FN_SRL = 6'b000110;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL
  } alu_op_e;

  // Non-shift ALU operations; shifts are handled in the core so they can be compiled out.
  function automatic logic [31:0] alu_eval(alu_op_e op, logic [31:0] x, logic [31:0] y);
    logic [31:0] r;
    case (op)
      ALU_SUB: r = x - y;
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_SLT: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: r = x + y;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// asynchronous clear, R0 hardwired to zero.
module reg_file
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra_addr,
  output logic [31:0] ra_data,
  input  logic [4:0]  rb_addr,
  output logic [31:0] rb_data,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] Registers [32];

  // Combinational reads; R0 always returns zero.
  always_comb begin
    ra_data = (ra_addr == 5'd0) ? 32'd0 : Registers[ra_addr];
    rb_data = (rb_addr == 5'd0) ? 32'd0 : Registers[rb_addr];
  end

  // Write port with async clear; writes aimed at R0 are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) Registers[i] <= 32'd0;
    end else if (we && (wa != 5'd0)) begin
      Registers[wa] <= wd;
    end
  end

endmodule

// File: rtl/cpu.sv
// Single-cycle word-addressed mini-MIPS core with inline instruction/data memories
// and a reset-time loader. Optional macro CPU_SHIFT_EN enables sll/srl.
module cpu
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         inst_data,
  input  logic [ADDR_W-1:0]   address,
  input  logic                write_instruction,
  input  logic                write_data,
  output logic [31:0]         OutputOfRs
);

  logic [ADDR_W-1:0] PC;
  logic [ADDR_W-1:0] pc_d;
  logic [31:0]       imem [MEM_DEPTH];
  logic [31:0]       inst;

  logic [5:0]  f_op;
  logic [4:0]  f_a;
  logic [4:0]  f_b;
  logic [4:0]  f_c;
  logic [5:0]  f_funct;
  logic [31:0] imm_ext;

  logic [4:0]  ra_addr;
  logic [4:0]  rb_addr;
  logic [31:0] ra_data;
  logic [31:0] rb_data;
  logic        reg_we;
  logic [31:0] wr_data;

  alu_op_e     alu_op;
  logic        use_imm;
  logic        wb_from_mem;
  logic        is_beq;
  logic        is_bne;
  logic        is_j;
  logic        mem_we;
  logic [31:0] alu_b;
  logic [31:0] alu_y;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       dmem_rdata;

  assign inst    = imem[PC];
  assign f_op    = inst[31:26];
  assign f_a     = inst[25:21];
  assign f_b     = inst[20:16];
  assign f_c     = inst[15:11];
  assign f_funct = inst[5:0];
  assign imm_ext = {{16{inst[15]}}, inst[15:0]};

  // Instruction memory is only writable through the loader while reset is held.
  always_ff @(posedge clk) begin
    if (rst && write_instruction) imem[address] <= inst_data;
  end

  reg_file RAM (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (ra_addr),
    .ra_data (ra_data),
    .rb_addr (rb_addr),
    .rb_data (rb_data),
    .we      (reg_we),
    .wa      (f_a),
    .wd      (wr_data)
  );

  assign OutputOfRs = ra_data;

  // Decode: register addresses and control from the instruction word alone.
  always_comb begin
    ra_addr     = f_b;
    rb_addr     = f_c;
    alu_op      = ALU_ADD;
    use_imm     = 1'b1;
    reg_we      = 1'b0;
    wb_from_mem = 1'b0;
    mem_we      = 1'b0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
    is_j        = 1'b0;
    case (f_op)
      OP_RTYPE: begin
        use_imm = 1'b0;
        case (f_funct)
          FN_ADD: begin alu_op = ALU_ADD; reg_we = 1'b1; end
          FN_SUB: begin alu_op = ALU_SUB; reg_we = 1'b1; end
          FN_AND: begin alu_op = ALU_AND; reg_we = 1'b1; end
          FN_OR:  begin alu_op = ALU_OR;  reg_we = 1'b1; end
          FN_SLT: begin alu_op = ALU_SLT; reg_we = 1'b1; end
`ifdef CPU_SHIFT_EN
          FN_SLL: begin alu_op = ALU_SLL; reg_we = 1'b1; end
          FN_SRL: begin alu_op = ALU_SRL; reg_we = 1'b1; end
`endif
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI: reg_we = 1'b1;
      OP_LW: begin
        reg_we      = 1'b1;
        wb_from_mem = 1'b1;
      end
      OP_SW: begin
        ra_addr = f_a;
        rb_addr = f_b;
        mem_we  = 1'b1;
      end
      OP_BEQ: begin
        ra_addr = f_a;
        rb_addr = f_b;
        is_beq  = 1'b1;
      end
      OP_BNE: begin
        ra_addr = f_a;
        rb_addr = f_b;
        is_bne  = 1'b1;
      end
      OP_J:    is_j = 1'b1;
      default: reg_we = 1'b0;
    endcase
  end

  // Execute: ALU result, including the optional shifter operating on R[C].
  always_comb begin
    alu_b = use_imm ? imm_ext : rb_data;
    alu_y = alu_eval(alu_op, ra_data, alu_b);
`ifdef CPU_SHIFT_EN
    if (alu_op == ALU_SLL) alu_y = rb_data << inst[10:6];
    if (alu_op == ALU_SRL) alu_y = rb_data >> inst[10:6];
`endif
  end

  assign mem_addr  = alu_y[ADDR_W-1:0];
  assign mem_wdata = rb_data;
  assign wr_data   = wb_from_mem ? dmem_rdata : alu_y;

  if (1) begin : data_mem
    logic [31:0]       Address_locations [MEM_DEPTH];
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    logic              we;

    assign a          = mem_addr;
    assign d          = mem_wdata;
    assign we         = mem_we;
    assign dmem_rdata = Address_locations[a];

    // Loader writes while in reset; core stores otherwise. Reset does not clear contents.
    always_ff @(posedge clk) begin
      if (rst) begin
        if (write_data) Address_locations[address] <= inst_data;
      end else if (we) begin
        Address_locations[a] <= d;
      end
    end
  end

  // Next-PC selection: jump, taken branch, or sequential; all wraps modulo 1024.
  always_comb begin
    pc_d = PC + 10'd1;
    if (is_j) pc_d = inst[9:0];
    else if ((is_beq && (ra_data == rb_data)) || (is_bne && (ra_data != rb_data)))
      pc_d = PC + 10'd1 + imm_ext[9:0];
  end

  // Program counter register with async reset to address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) PC <= '0;
    else     PC <= pc_d;
  end

endmodule

// File: tb/tb_cpu.sv
// Directed self-checking bench for the mini-MIPS core.
module tb_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_data = 32'd0;
  logic [9:0]  address = 10'd0;
  logic        write_instruction = 1'b0;
  logic        write_data = 1'b0;
  logic [31:0] OutputOfRs;

  int checks = 0;
  int failures = 0;

  cpu dut (
    .clk               (clk),
    .rst               (rst),
    .inst_data         (inst_data),
    .address           (address),
    .write_instruction (write_instruction),
    .write_data        (write_data),
    .OutputOfRs        (OutputOfRs)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ei(logic [5:0] op, logic [4:0] a, logic [4:0] b, logic [15:0] imm);
    return {op, a, b, imm};
  endfunction

  function automatic logic [31:0] er(logic [5:0] fn, logic [4:0] a, logic [4:0] b, logic [4:0] c, logic [4:0] sh);
    return {6'b000000, a, b, c, sh, fn};
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", name, got);
    end
  endtask

  task automatic load(logic [9:0] a, logic [31:0] d, logic wi, logic wd);
    @(negedge clk);
    address = a; inst_data = d; write_instruction = wi; write_data = wd;
    @(posedge clk); #1;
    write_instruction = 1'b0; write_data = 1'b0;
  endtask

  task automatic enter_reset();
    #2 rst = 1'b1;
    for (int i = 0; i < 16; i++) load(10'(i), 32'd0, 1'b1, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load_main();
    load(0, ei(6'b000001, 31, 0, 1), 1, 0);
    load(1, ei(6'b000001, 31, 0, 10), 1, 0);
    load(2, ei(6'b000001, 27, 0, 10), 1, 0);
    load(3, er(6'b000000, 1, 27, 31, 0), 1, 0);
    load(4, ei(6'b010000, 31, 27, 1), 1, 0);
    load(5, ei(6'b000001, 1, 0, 15), 1, 0);
    load(6, ei(6'b001000, 31, 27, 0), 1, 0);
    load(7, ei(6'b000111, 1, 0, 10), 1, 0);
    load(8, ei(6'b000111, 2, 0, 6), 1, 0);
    load(6, 32'd7, 0, 1);
    load(10, 32'd0, 0, 1);
  endtask

  task automatic test_reset();
    chk("reset_pc", 32'(dut.PC), 32'd0);
    chk("reset_r31", dut.RAM.Registers[31], 32'd0);
    chk("reset_rs", OutputOfRs, 32'd0);
  endtask

  task automatic test_main();
    logic saw15;
    enter_reset();
    load_main();
    release_reset();
    chk("main_pc_before_first_edge", 32'(dut.PC), 32'd0);
    step(1);
    chk("main_first_instr_r31", dut.RAM.Registers[31], 32'd1);
    chk("main_first_instr_pc", 32'(dut.PC), 32'd1);
    saw15 = 1'b0;
    for (int i = 1; i < 20; i++) begin
      step(1);
      if (dut.RAM.Registers[1] == 32'd15) saw15 = 1'b1;
    end
    chk("main_r1", dut.RAM.Registers[1], 32'd10);
    chk("main_r2", dut.RAM.Registers[2], 32'd7);
    chk("main_m10", dut.data_mem.Address_locations[10], 32'd10);
    chk("main_r1_never_15", {31'd0, saw15}, 32'd0);
  endtask

  task automatic test_branch();
    enter_reset();
    load(0, ei(6'b000001, 1, 0, 3), 1, 0);
    load(1, ei(6'b000001, 2, 0, 4), 1, 0);
    load(2, ei(6'b010000, 1, 2, 5), 1, 0);
    load(3, ei(6'b010001, 1, 1, 5), 1, 0);
    load(4, ei(6'b010001, 1, 2, 16'hFFFE), 1, 0);
    release_reset();
    step(2);
    chk("branch_rs_is_fieldA", OutputOfRs, 32'd3);
    step(1);
    chk("beq_not_taken_pc", 32'(dut.PC), 32'd3);
    step(1);
    chk("bne_not_taken_pc", 32'(dut.PC), 32'd4);
    step(1);
    chk("bne_taken_back_pc", 32'(dut.PC), 32'd3);
  endtask

  task automatic test_r0();
    enter_reset();
    load(0, ei(6'b000001, 0, 0, 5), 1, 0);
    load(1, ei(6'b000001, 4, 0, 0), 1, 0);
    release_reset();
    step(1);
    chk("r0_reads_zero", dut.RAM.Registers[0], 32'd0);
    chk("r0_rs_port", OutputOfRs, 32'd0);
    step(1);
    chk("r0_copy_r4", dut.RAM.Registers[4], 32'd0);
  endtask

  task automatic test_alu();
    logic [31:0] e_sll;
    logic [31:0] e_srl;
    enter_reset();
    load(0,  ei(6'b000001, 1, 0, 3), 1, 0);
    load(1,  ei(6'b000001, 2, 0, 5), 1, 0);
    load(2,  er(6'b000001, 3, 1, 2, 0), 1, 0);
    load(3,  ei(6'b000001, 4, 0, 16'hFFFF), 1, 0);
    load(4,  ei(6'b000001, 5, 0, 1), 1, 0);
    load(5,  er(6'b000100, 6, 4, 5, 0), 1, 0);
    load(6,  er(6'b000100, 7, 5, 4, 0), 1, 0);
    load(7,  er(6'b000101, 8, 0, 5, 31), 1, 0);
    load(8,  er(6'b000110, 9, 0, 8, 31), 1, 0);
    load(9,  er(6'b000010, 10, 1, 2, 0), 1, 0);
    load(10, er(6'b000011, 11, 1, 2, 0), 1, 0);
    release_reset();
    step(12);
`ifdef CPU_SHIFT_EN
    e_sll = 32'h80000000;
    e_srl = 32'd1;
`else
    e_sll = 32'd0;
    e_srl = 32'd0;
`endif
    chk("alu_sub_3_minus_5", dut.RAM.Registers[3], 32'hFFFFFFFE);
    chk("alu_slt_m1_lt_1", dut.RAM.Registers[6], 32'd1);
    chk("alu_slt_1_lt_m1", dut.RAM.Registers[7], 32'd0);
    chk("alu_sll_31", dut.RAM.Registers[8], e_sll);
    chk("alu_srl_31", dut.RAM.Registers[9], e_srl);
    chk("alu_and", dut.RAM.Registers[10], 32'd1);
    chk("alu_or", dut.RAM.Registers[11], 32'd7);
  endtask

  task automatic test_wrap();
    enter_reset();
    load(0, ei(6'b000001, 1, 0, 16'd1000), 1, 0);
    load(1, ei(6'b000111, 2, 1, 16'd30), 1, 0);
    load(2, {6'b000010, 26'd1023}, 1, 0);
    load(6, 32'h12345678, 0, 1);
    release_reset();
    step(2);
    chk("wrap_lw_1030_reads_m6", dut.RAM.Registers[2], 32'h12345678);
    step(1);
    chk("wrap_jump_1023", 32'(dut.PC), 32'd1023);
    step(1);
    chk("wrap_pc_to_0", 32'(dut.PC), 32'd0);
  endtask

  task automatic test_midrun_reset();
    enter_reset();
    load_main();
    release_reset();
    step(7);
    chk("mid_sw_then_m10", dut.data_mem.Address_locations[10], 32'd10);
    @(negedge clk);
    address = 10'd6; inst_data = 32'hDEADBEEF; write_data = 1'b1; write_instruction = 1'b1;
    step(1);
    write_data = 1'b0; write_instruction = 1'b0;
    chk("loader_ignored_when_running", dut.data_mem.Address_locations[6], 32'd7);
    chk("mid_sw_lw_back_to_back_r1", dut.RAM.Registers[1], 32'd10);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_pc", 32'(dut.PC), 32'd0);
    chk("mid_reset_r1", dut.RAM.Registers[1], 32'd0);
    chk("mid_reset_r27", dut.RAM.Registers[27], 32'd0);
    chk("mid_reset_m10_kept", dut.data_mem.Address_locations[10], 32'd10);
    step(1);
    chk("mid_reset_hold_r31", dut.RAM.Registers[31], 32'd0);
    release_reset();
    step(20);
    chk("rerun_r1", dut.RAM.Registers[1], 32'd10);
    chk("rerun_r2", dut.RAM.Registers[2], 32'd7);
    chk("rerun_r31", dut.RAM.Registers[31], 32'd10);
    chk("rerun_m10", dut.data_mem.Address_locations[10], 32'd10);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) load(10'(i), 32'd0, 1'b1, 1'b1);
    test_reset();
    test_main();
    test_branch();
    test_r0();
    test_alu();
    test_wrap();
    test_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
